// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 host sequencer and its bus-cycle timer.
package pic_pkg;

  typedef enum logic [3:0] {
    ST_UNINIT,
    ST_INIT_WR,
    ST_READY,
    ST_INTA1,
    ST_GAP,
    ST_INTA2,
    ST_VEC_HOLD,
    ST_EOI_WR,
    ST_IMR_WR
  } seq_state_t;

  typedef enum logic [2:0] {
    IDX_ICW1,
    IDX_ICW2,
    IDX_ICW3,
    IDX_ICW4,
    IDX_OCW1
  } init_idx_t;

  typedef enum logic {
    BUS_WRITE,
    BUS_INTA
  } bus_kind_t;

  typedef enum logic [2:0] {
    BC_IDLE,
    BC_SETUP,
    BC_STROBE,
    BC_HOLD,
    BC_IDLE1
  } bus_phase_t;

  localparam logic [7:0] OCW2_NS_EOI   = 8'h20;
  localparam logic [7:0] ICW1_BASE     = 8'h10;
  localparam int         ICW1_IC4_BIT  = 0;
  localparam int         ICW1_SNGL_BIT = 1;
  localparam int         ICW1_LTIM_BIT = 3;
  localparam int         ICW4_UPM_BIT  = 0;
  localparam int         ICW4_AEOI_BIT = 1;

endpackage

// File: rtl/pic_bus_cycle.sv
// Single PIC bus transaction timer: a write (SETUP/STROBE/HOLD/IDLE1) or one INTA low pulse.
module pic_bus_cycle
  import pic_pkg::*;
#(
  parameter int STROBE_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  bus_kind_t  kind,
  input  logic       a0_in,
  input  logic [7:0] data_in,
  output logic       done,
  output logic       cs_n,
  output logic       wr_n,
  output logic       inta_n,
  output logic       a0,
  output logic [7:0] dout
);

  localparam int CW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STROBE_CYC - 1);

  bus_phase_t     phase, phase_nxt;
  bus_kind_t      kind_q;
  logic [CW-1:0]  cnt;
  logic           at_last;
  logic           accept;

  assign at_last = (cnt == CNT_LAST);
  assign accept  = go && (phase == BC_IDLE || phase == BC_IDLE1);

  // a0/dout are latched only for writes so they stay stable through SETUP..HOLD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase  <= BC_IDLE;
      kind_q <= BUS_WRITE;
      cnt    <= '0;
      a0     <= 1'b0;
      dout   <= 8'h00;
    end else begin
      phase <= phase_nxt;
      if (accept) begin
        kind_q <= kind;
        cnt    <= '0;
        if (kind == BUS_WRITE) begin
          a0   <= a0_in;
          dout <= data_in;
        end
      end else if (phase == BC_STROBE && !at_last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    phase_nxt = phase;
    case (phase)
      BC_IDLE, BC_IDLE1: begin
        if (go) phase_nxt = (kind == BUS_WRITE) ? BC_SETUP : BC_STROBE;
        else    phase_nxt = BC_IDLE;
      end
      BC_SETUP:  phase_nxt = BC_STROBE;
      BC_STROBE: if (at_last) phase_nxt = (kind_q == BUS_WRITE) ? BC_HOLD : BC_IDLE;
      BC_HOLD:   phase_nxt = BC_IDLE1;
      default:   phase_nxt = BC_IDLE;
    endcase
  end

  always_comb begin
    cs_n   = !((phase == BC_SETUP || phase == BC_STROBE || phase == BC_HOLD) && kind_q == BUS_WRITE);
    wr_n   = !(phase == BC_STROBE && kind_q == BUS_WRITE);
    inta_n = !(phase == BC_STROBE && kind_q == BUS_INTA);
    done   = (phase == BC_IDLE1) || (phase == BC_STROBE && kind_q == BUS_INTA && at_last);
  end

endmodule

// File: rtl/pic_host_sequencer.sv
// Host-side 8259 controller: init ICW/OCW1 writes, two-pulse INTA, EOI and mask writes.
// Define PIC_CASCADE_EN to clear SNGL and insert the ICW3 write during init.
module pic_host_sequencer
  import pic_pkg::*;
#(
  parameter logic [7:0] VECTOR_BASE = 8'h08,
  parameter bit         LEVEL_TRIG  = 1'b0,
  parameter bit         AUTO_EOI    = 1'b0,
  parameter logic [7:0] IMR_INIT    = 8'hFF,
  parameter logic [7:0] ICW3_VAL    = 8'h04,
  parameter int         STROBE_CYC  = 2,
  parameter int         GAP_CYC     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       init_done,
  output logic       busy,
  input  logic       irq,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  input  logic       vec_ack,
  input  logic       eoi_req,
  output logic       eoi_done,
  input  logic       imr_req,
  input  logic [7:0] imr_data,
  output logic       imr_done,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       inta_n,
  output logic       a0,
  output logic [7:0] dout,
  input  logic [7:0] din
);

`ifdef PIC_CASCADE_EN
  localparam bit SNGL = 1'b0;
`else
  localparam bit SNGL = 1'b1;
`endif

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  function automatic logic [7:0] init_data(init_idx_t i);
    case (i)
      IDX_ICW1: init_data = ICW1_BASE | (8'(LEVEL_TRIG) << ICW1_LTIM_BIT) |
                            (8'(SNGL) << ICW1_SNGL_BIT) | (8'd1 << ICW1_IC4_BIT);
      IDX_ICW2: init_data = {VECTOR_BASE[7:3], 3'b000};
      IDX_ICW3: init_data = ICW3_VAL;
      IDX_ICW4: init_data = (8'd1 << ICW4_UPM_BIT) | (8'(AUTO_EOI) << ICW4_AEOI_BIT);
      default:  init_data = IMR_INIT;
    endcase
  endfunction

  function automatic init_idx_t next_idx(init_idx_t i);
    case (i)
      IDX_ICW1: next_idx = IDX_ICW2;
      IDX_ICW2: next_idx = SNGL ? IDX_ICW4 : IDX_ICW3;
      IDX_ICW3: next_idx = IDX_ICW4;
      default:  next_idx = IDX_OCW1;
    endcase
  endfunction

  seq_state_t    state, state_nxt;
  init_idx_t     idx, idx_nxt, nidx;
  logic          start_pend, start_any;
  logic          irq_meta, irq_sync;
  logic [GW-1:0] gap_cnt;
  logic          gap_last;
  logic          go, go_a0, bus_done;
  bus_kind_t     go_kind;
  logic [7:0]    go_data;
  logic          init_launch, init_finish, capture;

  assign start_any = start || start_pend;
  assign gap_last  = (gap_cnt == GW'(GAP_CYC - 1));
  assign capture   = (state == ST_INTA2) && bus_done;
  assign rd_n      = 1'b1;

  pic_bus_cycle #(.STROBE_CYC(STROBE_CYC)) u_bus (
    .clk     (clk),
    .reset   (reset),
    .go      (go),
    .kind    (go_kind),
    .a0_in   (go_a0),
    .data_in (go_data),
    .done    (bus_done),
    .cs_n    (cs_n),
    .wr_n    (wr_n),
    .inta_n  (inta_n),
    .a0      (a0),
    .dout    (dout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_UNINIT;
      idx        <= IDX_ICW1;
      start_pend <= 1'b0;
      init_done  <= 1'b0;
      vec_data   <= 8'h00;
      irq_meta   <= 1'b0;
      irq_sync   <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      start_pend <= start_any && !init_launch;
      irq_meta   <= irq;
      irq_sync   <= irq_meta;
      gap_cnt    <= (state == ST_GAP && !gap_last) ? gap_cnt + 1'b1 : '0;
      if (init_launch)      init_done <= 1'b0;
      else if (init_finish) init_done <= 1'b1;
      if (capture) vec_data <= din;
    end
  end

  // Transitions and bus launches; a queued start preempts at the next IDLE1 of a write
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    nidx        = next_idx(idx);
    go          = 1'b0;
    go_kind     = BUS_WRITE;
    go_a0       = 1'b0;
    go_data     = 8'h00;
    init_launch = 1'b0;
    init_finish = 1'b0;
    case (state)
      ST_UNINIT: if (start_any) init_launch = 1'b1;
      ST_READY: begin
        if (start_any) begin
          init_launch = 1'b1;
        end else if (init_done && irq_sync) begin
          state_nxt = ST_INTA1;
          go        = 1'b1;
          go_kind   = BUS_INTA;
        end else if (init_done && eoi_req) begin
          state_nxt = ST_EOI_WR;
          go        = !AUTO_EOI;
          go_data   = OCW2_NS_EOI;
        end else if (init_done && imr_req) begin
          state_nxt = ST_IMR_WR;
          go        = 1'b1;
          go_a0     = 1'b1;
          go_data   = imr_data;
        end
      end
      ST_INIT_WR: begin
        if (bus_done) begin
          if (start_any) begin
            init_launch = 1'b1;
          end else if (idx == IDX_OCW1) begin
            state_nxt   = ST_READY;
            init_finish = 1'b1;
          end else begin
            idx_nxt = nidx;
            go      = 1'b1;
            go_a0   = 1'b1;
            go_data = init_data(nidx);
          end
        end
      end
      ST_EOI_WR: begin
        if (AUTO_EOI || bus_done) begin
          if (start_any) init_launch = 1'b1;
          else           state_nxt   = ST_READY;
        end
      end
      ST_IMR_WR: begin
        if (bus_done) begin
          if (start_any) init_launch = 1'b1;
          else           state_nxt   = ST_READY;
        end
      end
      ST_INTA1: if (bus_done) state_nxt = ST_GAP;
      ST_GAP: begin
        if (gap_last) begin
          state_nxt = ST_INTA2;
          go        = 1'b1;
          go_kind   = BUS_INTA;
        end
      end
      ST_INTA2: if (bus_done) state_nxt = ST_VEC_HOLD;
      ST_VEC_HOLD: begin
        if (start_any)    init_launch = 1'b1;
        else if (vec_ack) state_nxt   = ST_READY;
      end
      default: state_nxt = ST_UNINIT;
    endcase
    if (init_launch) begin
      state_nxt = ST_INIT_WR;
      idx_nxt   = IDX_ICW1;
      go        = 1'b1;
      go_kind   = BUS_WRITE;
      go_a0     = 1'b0;
      go_data   = init_data(IDX_ICW1);
    end
  end

  always_comb begin
    busy      = !(state inside {ST_UNINIT, ST_READY, ST_VEC_HOLD}) &&
                !(state == ST_EOI_WR && AUTO_EOI);
    vec_valid = (state == ST_VEC_HOLD);
    eoi_done  = (state == ST_EOI_WR) && (AUTO_EOI || bus_done);
    imr_done  = (state == ST_IMR_WR) && bus_done;
  end

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Directed bench for pic_host_sequencer: init writes, INTA, EOI/IMR ordering, reset, auto-EOI.
module tb_pic_host_sequencer;

  logic       clk, reset, start, irq, vec_ack, eoi_req, imr_req;
  logic [7:0] imr_data, din;
  logic       init_done, busy, vec_valid, eoi_done, imr_done;
  logic       cs_n, wr_n, rd_n, inta_n, a0;
  logic [7:0] vec_data, dout;

  logic       ae_eoi;
  logic       ae_init_done, ae_busy, ae_vec_valid, ae_eoi_done, ae_imr_done;
  logic       ae_cs_n, ae_wr_n, ae_rd_n, ae_inta_n, ae_a0;
  logic [7:0] ae_vec_data, ae_dout;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef PIC_CASCADE_EN
  localparam int NWR = 5;
  localparam logic [7:0] EXP_D [NWR] = '{8'h11, 8'h08, 8'h04, 8'h01, 8'hFF};
  localparam logic       EXP_A [NWR] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
  localparam int NWR = 4;
  localparam logic [7:0] EXP_D [NWR] = '{8'h13, 8'h08, 8'h01, 8'hFF};
  localparam logic       EXP_A [NWR] = '{1'b0, 1'b1, 1'b1, 1'b1};
`endif
  // each write is 5 cycles (4 with cs_n low plus IDLE1); init_done follows one cycle later
  localparam int INIT_LAT = NWR * 5 + 1;

  pic_host_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .init_done(init_done), .busy(busy),
    .irq(irq), .vec_valid(vec_valid), .vec_data(vec_data), .vec_ack(vec_ack),
    .eoi_req(eoi_req), .eoi_done(eoi_done), .imr_req(imr_req), .imr_data(imr_data),
    .imr_done(imr_done), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .inta_n(inta_n),
    .a0(a0), .dout(dout), .din(din)
  );

  pic_host_sequencer #(.AUTO_EOI(1'b1)) dut_ae (
    .clk(clk), .reset(reset), .start(start), .init_done(ae_init_done), .busy(ae_busy),
    .irq(1'b0), .vec_valid(ae_vec_valid), .vec_data(ae_vec_data), .vec_ack(1'b0),
    .eoi_req(ae_eoi), .eoi_done(ae_eoi_done), .imr_req(1'b0), .imr_data(8'h00),
    .imr_done(ae_imr_done), .cs_n(ae_cs_n), .wr_n(ae_wr_n), .rd_n(ae_rd_n), .inta_n(ae_inta_n),
    .a0(ae_a0), .dout(ae_dout), .din(8'h00)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] wd_q [$];
  logic       a0_q [$];
  int         wl_q [$];
  int         cl_q [$];
  logic [8:0] log_q [$];
  int         il_q [$];
  int         ig_q [$];
  int         cs_run, wr_run, inta_low_run, inta_high_run, ae_cs_low;
  bit         have_pulse;
  logic       cur_a0;
  logic [7:0] cur_d;

  // Bus monitor: one record per cs_n window, INTA pulse/gap lengths, and an ordered event log
  always @(negedge clk) begin
    if (!ae_cs_n) ae_cs_low++;
    if (reset) begin
      cs_run = 0; wr_run = 0; inta_low_run = 0; inta_high_run = 0;
    end else begin
      if (!cs_n) begin
        cs_run++;
        if (!wr_n) begin
          if (wr_run == 0) begin cur_a0 = a0; cur_d = dout; end
          wr_run++;
        end
      end else if (cs_run != 0) begin
        wd_q.push_back(cur_d); a0_q.push_back(cur_a0);
        wl_q.push_back(wr_run); cl_q.push_back(cs_run);
        log_q.push_back({1'b0, cur_d});
        cs_run = 0; wr_run = 0;
      end
      if (!inta_n) begin
        if (inta_low_run == 0) begin
          log_q.push_back(9'h100);
          if (have_pulse) ig_q.push_back(inta_high_run);
        end
        inta_low_run++;
        inta_high_run = 0;
      end else begin
        if (inta_low_run != 0) begin
          il_q.push_back(inta_low_run);
          have_pulse = 1'b1;
          inta_low_run = 0;
        end
        inta_high_run++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic i, input logic e, input logic m,
                               input logic [7:0] md, input logic [7:0] d, input logic ack);
    start = s; irq = i; eoi_req = e; imr_req = m; imr_data = md; din = d; vec_ack = ack;
  endtask

  task automatic clearQueues();
    wd_q.delete(); a0_q.delete(); wl_q.delete(); cl_q.delete();
    log_q.delete(); il_q.delete(); ig_q.delete();
  endtask

  task automatic runInit(output int cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!init_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic checkInitWrites(input string pfx);
    checkOutput({pfx, "_nwrites"}, wd_q.size(), NWR);
    for (int k = 0; k < NWR; k++) begin
      checkOutput($sformatf("%s_wr%0d_data", pfx, k), (wd_q.size() > k) ? 32'(wd_q[k]) : 32'hFFFF, 32'(EXP_D[k]));
      checkOutput($sformatf("%s_wr%0d_a0", pfx, k), (a0_q.size() > k) ? 32'(a0_q[k]) : 32'hFFFF, 32'(EXP_A[k]));
      checkOutput($sformatf("%s_wr%0d_wrlow", pfx, k), (wl_q.size() > k) ? wl_q[k] : -1, 2);
      checkOutput($sformatf("%s_wr%0d_cslow", pfx, k), (cl_q.size() > k) ? cl_q[k] : -1, 4);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc, n, cnt;
    reset = 1'b1; ae_eoi = 1'b0;
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 0);
    repeat (2) @(negedge clk);
    checkOutput("rst_strobes", {cs_n, wr_n, rd_n, inta_n}, 4'hF);
    checkOutput("rst_a0_dout", {a0, dout}, 9'h000);
    checkOutput("rst_vec_data", vec_data, 8'h00);
    checkOutput("rst_flags", {init_done, busy, vec_valid, eoi_done, imr_done}, 5'b0);
    reset = 1'b0;
    @(negedge clk);

    // T1 init sequence
    runInit(cyc);
    checkOutput("t1_init_latency", cyc, INIT_LAT);
    checkOutput("t1_init_done", init_done, 1);
    checkOutput("t1_busy_after", busy, 0);
    checkInitWrites("t1");
    checkOutput("t1_ae_init_done", ae_init_done, 1);

    // T2 INTA
    clearQueues();
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h0B, 0);
    n = 0;
    while (!vec_valid && n < 50) begin @(negedge clk); n++; end
    checkOutput("t2_vec_valid", vec_valid, 1);
    checkOutput("t2_vec_data", vec_data, 8'h0B);
    repeat (10) @(negedge clk);
    checkOutput("t2_vec_held", vec_valid, 1);
    checkOutput("t2_inta_pulses", il_q.size(), 2);
    checkOutput("t2_inta1_low", (il_q.size() > 0) ? il_q[0] : -1, 2);
    checkOutput("t2_inta_gap", (ig_q.size() > 0) ? ig_q[0] : -1, 1);
    checkOutput("t2_inta2_low", (il_q.size() > 1) ? il_q[1] : -1, 2);
    checkOutput("t2_no_cs", wd_q.size(), 0);
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h0B, 0);
    repeat (4) @(negedge clk);
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h0B, 1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h0B, 0);
    checkOutput("t2_vec_cleared", vec_valid, 0);
    repeat (5) @(negedge clk);
    checkOutput("t2_no_more_inta", il_q.size(), 2);

    // T3 EOI write
    clearQueues();
    applyStimulus(0, 0, 1, 0, 8'h00, 8'h00, 0);
    n = 0;
    while (!eoi_done && n < 30) begin @(negedge clk); n++; end
    checkOutput("t3_eoi_done", eoi_done, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    checkOutput("t3_eoi_pulse", eoi_done, 0);
    checkOutput("t3_nwrites", wd_q.size(), 1);
    checkOutput("t3_data", (wd_q.size() > 0) ? 32'(wd_q[0]) : 32'hFFFF, 8'h20);
    checkOutput("t3_a0", (a0_q.size() > 0) ? 32'(a0_q[0]) : 32'hFFFF, 0);
    checkOutput("t3_rd_n", rd_n, 1);

    // T3b auto-EOI instance
    ae_cs_low = 0;
    ae_eoi = 1'b1;
    @(negedge clk);
    checkOutput("t3b_eoi_done", ae_eoi_done, 1);
    ae_eoi = 1'b0;
    @(negedge clk);
    checkOutput("t3b_eoi_pulse", ae_eoi_done, 0);
    checkOutput("t3b_no_cs", ae_cs_low, 0);
    checkOutput("t3b_outs", {ae_busy, ae_vec_valid, ae_imr_done, ae_wr_n, ae_rd_n, ae_inta_n, ae_a0}, 7'b0001111);
    checkOutput("t3b_data", {ae_vec_data, ae_dout}, 16'h00FF);

    // T4 simultaneous requests while a mask write is on the bus
    clearQueues();
    applyStimulus(0, 0, 0, 1, 8'hC3, 8'h4C, 0);
    n = 0;
    while (cs_n && n < 10) begin @(negedge clk); n++; end
    checkOutput("t4_first_busy", cs_n, 0);
    applyStimulus(0, 1, 1, 1, 8'h5A, 8'h4C, 0);
    n = 0;
    while (!imr_done && n < 20) begin @(negedge clk); n++; end
    checkOutput("t4_imr1_done", imr_done, 1);
    n = 0;
    while (!vec_valid && n < 40) begin @(negedge clk); n++; end
    checkOutput("t4_vec_valid", vec_valid, 1);
    checkOutput("t4_vec_data", vec_data, 8'h4C);
    applyStimulus(0, 0, 1, 1, 8'h5A, 8'h4C, 0);
    repeat (4) @(negedge clk);
    applyStimulus(0, 0, 1, 1, 8'h5A, 8'h4C, 1);
    @(negedge clk);
    applyStimulus(0, 0, 1, 1, 8'h5A, 8'h4C, 0);
    n = 0;
    while (!eoi_done && n < 30) begin @(negedge clk); n++; end
    checkOutput("t4_eoi_done", eoi_done, 1);
    applyStimulus(0, 0, 0, 1, 8'h5A, 8'h4C, 0);
    n = 0;
    while (!imr_done && n < 30) begin @(negedge clk); n++; end
    checkOutput("t4_imr2_done", imr_done, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 0);
    repeat (2) @(negedge clk);
    checkOutput("t4_nevents", log_q.size(), 5);
    checkOutput("t4_ev0", (log_q.size() > 0) ? 32'(log_q[0]) : 32'hFFFF, 9'h0C3);
    checkOutput("t4_ev1", (log_q.size() > 1) ? 32'(log_q[1]) : 32'hFFFF, 9'h100);
    checkOutput("t4_ev2", (log_q.size() > 2) ? 32'(log_q[2]) : 32'hFFFF, 9'h100);
    checkOutput("t4_ev3", (log_q.size() > 3) ? 32'(log_q[3]) : 32'hFFFF, 9'h020);
    checkOutput("t4_ev4", (log_q.size() > 4) ? 32'(log_q[4]) : 32'hFFFF, 9'h05A);
    checkOutput("t4_eoi_a0", (a0_q.size() > 1) ? 32'(a0_q[1]) : 32'hFFFF, 0);
    checkOutput("t4_imr_a0", (a0_q.size() > 2) ? 32'(a0_q[2]) : 32'hFFFF, 1);

    // T5 reset during ICW2 strobe, requests ignored before init, then rerun
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(wr_n == 1'b0 && a0 == 1'b1) && n < 40) begin @(negedge clk); n++; end
    checkOutput("t5_in_icw2_strobe", {wr_n, a0, dout}, {1'b0, 1'b1, 8'h08});
    #2 reset = 1'b1;
    #1;
    checkOutput("t5_strobes_released", {cs_n, wr_n, rd_n, inta_n}, 4'hF);
    checkOutput("t5_init_done_low", {init_done, busy}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clearQueues();
    applyStimulus(0, 1, 1, 1, 8'h33, 8'h00, 0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (eoi_done || imr_done || !cs_n || !inta_n || vec_valid) cnt++;
    end
    checkOutput("t5_ignored_uninit", cnt, 0);
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 0);
    repeat (4) @(negedge clk);
    runInit(cyc);
    checkOutput("t5_reinit_latency", cyc, INIT_LAT);
    checkInitWrites("t5");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
